// File: rtl/ysyx_23060042_pkg.sv
// Shared types for the memory arbiter: FSM states, transaction owner and the
// default abort timeout.
package ysyx_23060042_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/ysyx_23060042_memarb.sv
// IFU/LSU to single-port memory arbiter with one outstanding transaction and abort-on-timeout.
// Define YSYX_23060042_MEMARB_RR_EN for round-robin arbitration; default is fixed LSU priority.
module ysyx_23060042_memarb
  import ysyx_23060042_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rdata,
  output logic        rsp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ifu_rsp_q, ifu_rsp_d;
  logic        lsu_rsp_q, lsu_rsp_d;
  logic        err_q, err_d;
  logic [31:0] ifu_rdata_q, ifu_rdata_d;
  logic [31:0] lsu_rdata_q, lsu_rdata_d;
  logic        lsu_wins, grant_ifu, grant_lsu;
  logic        finish, abort;
  logic [31:0] rsp_data;

`ifdef YSYX_23060042_MEMARB_RR_EN
  owner_e last_grant_q, last_grant_d;

  // On a collision the requester that was not granted last time wins.
  assign lsu_wins     = lsu_req_valid && (!ifu_req_valid || last_grant_q == OWN_IFU);
  assign last_grant_d = grant_lsu ? OWN_LSU : (grant_ifu ? OWN_IFU : last_grant_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant_q <= OWN_IFU;
    else      last_grant_q <= last_grant_d;
  end
`else
  assign lsu_wins = lsu_req_valid;
`endif

  assign grant_lsu = (state_q == ST_IDLE) && lsu_wins;
  assign grant_ifu = (state_q == ST_IDLE) && ifu_req_valid && !lsu_wins;

  // Readies are gated by reset so every output is low while reset is held.
  assign ifu_req_ready = grant_ifu && rst;
  assign lsu_req_ready = grant_lsu && rst;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    cnt_d       = cnt_q;
    ifu_rsp_d   = 1'b0;
    lsu_rsp_d   = 1'b0;
    err_d       = 1'b0;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    finish      = 1'b0;
    abort       = 1'b0;
    rsp_data    = 32'h0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_lsu) begin
          owner_d = OWN_LSU;
          addr_d  = lsu_addr;
          wen_d   = lsu_wen;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wmask;
          cnt_d   = 8'd0;
          state_d = ST_REQ;
        end else if (grant_ifu) begin
          owner_d = OWN_IFU;
          addr_d  = ifu_addr;
          wen_d   = 1'b0;
          wdata_d = 32'h0;
          wmask_d = 4'h0;
          cnt_d   = 8'd0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_d == TimeoutCnt) abort = 1'b1;
        else if (mem_req_ready)  state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rsp_valid)               finish = 1'b1;
        else if (cnt_d == TimeoutCnt)    abort  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A real response beats a timeout landing in the same cycle.
    if (finish || abort) begin
      state_d  = ST_IDLE;
      err_d    = abort;
      rsp_data = (abort || wen_q) ? 32'h0 : mem_rdata;
      if (owner_q == OWN_LSU) begin
        lsu_rsp_d   = 1'b1;
        lsu_rdata_d = rsp_data;
      end else begin
        ifu_rsp_d   = 1'b1;
        ifu_rdata_d = rsp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IFU;
      addr_q      <= 32'h0;
      wen_q       <= 1'b0;
      wdata_q     <= 32'h0;
      wmask_q     <= 4'h0;
      cnt_q       <= 8'd0;
      ifu_rsp_q   <= 1'b0;
      lsu_rsp_q   <= 1'b0;
      err_q       <= 1'b0;
      ifu_rdata_q <= 32'h0;
      lsu_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      cnt_q       <= cnt_d;
      ifu_rsp_q   <= ifu_rsp_d;
      lsu_rsp_q   <= lsu_rsp_d;
      err_q       <= err_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign ifu_rsp_valid = ifu_rsp_q;
  assign lsu_rsp_valid = lsu_rsp_q;
  assign rsp_err       = err_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_rdata     = lsu_rdata_q;

endmodule

// File: tb/tb_ysyx_23060042_memarb.sv
// Self-checking bench for ysyx_23060042_memarb: the bench plays the memory from a
// word-addressed reference store and predicts grants, payloads and responses.
module tb_ysyx_23060042_memarb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        rsp_err;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] exp_ifu_rdata = 32'h0;
  logic [31:0] exp_lsu_rdata = 32'h0;
  bit          last_lsu = 1'b0;
  logic [31:0] mem_model [logic [29:0]];

`ifdef YSYX_23060042_MEMARB_RR_EN
  localparam bit RrMode = 1'b1;
`else
  localparam bit RrMode = 1'b0;
`endif

  always #5 clk = ~clk;

  ysyx_23060042_memarb #(.TIMEOUT(10)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata), .rsp_err(rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a[31:2])) return mem_model[a[31:2]];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w;
    w = mem_read(a);
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    mem_model[a[31:2]] = w;
  endtask

  function automatic bit lsu_wins(input bit iv, input bit lv);
    return lv && (!iv || !RrMode || !last_lsu);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Entered one step after the acceptance edge; acts as the memory and checks the response.
  task automatic serve(input bit is_lsu, input logic [31:0] addr, input bit wen,
                       input logic [31:0] wdata, input logic [3:0] wmask,
                       input int w1, input int w2);
    logic [31:0] rd, expv;
    rd   = wen ? 32'($urandom) : mem_read(addr);
    expv = wen ? 32'h0 : rd;
    for (int i = 0; i <= w1; i++) begin
      mem_req_ready = (i == w1);
      mem_rsp_valid = (i < w1) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata     = $urandom;
      #1;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_addr !== addr || mem_wen !== wen ||
          mem_wmask !== wmask || (wen && mem_wdata !== wdata))
        $display("[TB] FAIL req_payload valid=%0b addr=%h wen=%0b wdata=%h wmask=%h want 1 %h %0b %h %h",
                 mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, addr, wen, wdata, wmask);
      else passed++;
      checks++;
      if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0 || ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0)
        $display("[TB] FAIL busy_quiet_req ready=%0b%0b rsp=%0b%0b want 00 00",
                 ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid);
      else passed++;
      tick;
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    for (int i = 0; i <= w2; i++) begin
      mem_rsp_valid = (i == w2);
      mem_rdata     = (i == w2) ? rd : 32'($urandom);
      #1;
      checks++;
      if (mem_req_valid !== 1'b0 || ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0 ||
          ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0)
        $display("[TB] FAIL busy_quiet_wait memvalid=%0b ready=%0b%0b rsp=%0b%0b want 0 00 00",
                 mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid);
      else passed++;
      tick;
    end
    mem_rsp_valid = 1'b0;
    checks++;
    if (is_lsu) begin
      if (lsu_rsp_valid !== 1'b1 || ifu_rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
          lsu_rdata !== expv || ifu_rdata !== exp_ifu_rdata)
        $display("[TB] FAIL lsu_response rsp=%0b other=%0b err=%0b rdata=%h want %h hold=%h want %h",
                 lsu_rsp_valid, ifu_rsp_valid, rsp_err, lsu_rdata, expv, ifu_rdata, exp_ifu_rdata);
      else passed++;
      exp_lsu_rdata = expv;
    end else begin
      if (ifu_rsp_valid !== 1'b1 || lsu_rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
          ifu_rdata !== expv || lsu_rdata !== exp_lsu_rdata)
        $display("[TB] FAIL ifu_response rsp=%0b other=%0b err=%0b rdata=%h want %h hold=%h want %h",
                 ifu_rsp_valid, lsu_rsp_valid, rsp_err, ifu_rdata, expv, lsu_rdata, exp_lsu_rdata);
      else passed++;
      exp_ifu_rdata = expv;
    end
    if (wen) mem_write(addr, wdata, wmask);
  endtask

  task automatic run_round(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                           input bit lw, input logic [31:0] ld, input logic [3:0] lm,
                           input int w1, input int w2);
    bit lf;
    ifu_addr = ia; lsu_addr = la; lsu_wen = lw; lsu_wdata = ld; lsu_wmask = lm;
    ifu_req_valid = iv; lsu_req_valid = lv;
    #1;
    lf = lsu_wins(iv, lv);
    checks++;
    if (ifu_req_ready !== (iv && !lf) || lsu_req_ready !== lf)
      $display("[TB] FAIL grant ifu_ready=%0b lsu_ready=%0b want %0b %0b",
               ifu_req_ready, lsu_req_ready, iv && !lf, lf);
    else passed++;
    tick;
    last_lsu = lf;
    if (lf) begin lsu_req_valid = 1'b0; serve(1'b1, la, lw, ld, lm, w1, w2); end
    else begin ifu_req_valid = 1'b0; serve(1'b0, ia, 1'b0, 32'h0, 4'h0, w1, w2); end
    if (iv && lv) begin
      checks++;
      if ((lf ? ifu_req_ready : lsu_req_ready) !== 1'b1)
        $display("[TB] FAIL same_cycle_accept ready=%0b want 1", lf ? ifu_req_ready : lsu_req_ready);
      else passed++;
      tick;
      last_lsu = !lf;
      if (lf) begin ifu_req_valid = 1'b0; serve(1'b0, ia, 1'b0, 32'h0, 4'h0, w1, w2); end
      else begin lsu_req_valid = 1'b0; serve(1'b1, la, lw, ld, lm, w1, w2); end
    end
    tick;
    checks++;
    if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0)
      $display("[TB] FAIL pulse_width rsp=%0b%0b want 00", ifu_rsp_valid, lsu_rsp_valid);
    else passed++;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    lsu_addr = 32'h8000_1000; lsu_wen = 1'b1; lsu_wdata = 32'hFFFF_FFFF; lsu_wmask = 4'hF;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) #2; else begin tick; tick; end
      checks++;
      if ({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, rsp_err, mem_req_valid,
           mem_wen, mem_wmask, mem_addr, mem_wdata, ifu_rdata, lsu_rdata} !== '0)
        $display("[TB] FAIL reset_outputs ready=%0b%0b rsp=%0b%0b err=%0b memv=%0b addr=%h rdata=%h/%h want all 0",
                 ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, rsp_err, mem_req_valid,
                 mem_addr, ifu_rdata, lsu_rdata);
      else passed++;
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_ifu_read;
    mem_model[30'h2000_0000] = 32'hDEAD_BEEF;
    run_round(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'h0, 4'hF, 0, 0);
  endtask

  task automatic test_collision;
    for (int r = 0; r < 2; r++)
      run_round(1'b1, 1'b1, 32'h8000_0000, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'hF, 0, 0);
  endtask

  task automatic test_stall;
    ifu_addr = 32'h8000_0040; ifu_req_valid = 1'b1;
    #1;
    checks++;
    if (ifu_req_ready !== 1'b1) $display("[TB] FAIL stall_grant ready=%0b want 1", ifu_req_ready);
    else passed++;
    tick;
    last_lsu = 1'b0;
    ifu_req_valid = 1'b0;
    lsu_addr = 32'h8000_0044; lsu_wen = 1'b0; lsu_wmask = 4'h3; lsu_req_valid = 1'b1;
    serve(1'b0, 32'h8000_0040, 1'b0, 32'h0, 4'h0, 5, 0);
    checks++;
    if (lsu_req_ready !== 1'b1) $display("[TB] FAIL stall_release ready=%0b want 1", lsu_req_ready);
    else passed++;
    lsu_req_valid = 1'b0;
    tick;
  endtask

  task automatic test_timeout;
    ifu_addr = 32'h8000_0080; ifu_req_valid = 1'b1;
    #1;
    tick;
    last_lsu = 1'b0;
    ifu_req_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    for (int e = 1; e < 10; e++) begin
      tick;
      checks++;
      if (mem_req_valid !== 1'b1 || ifu_rsp_valid !== 1'b0)
        $display("[TB] FAIL timeout_pending edge=%0d memv=%0b rsp=%0b want 1 0", e, mem_req_valid, ifu_rsp_valid);
      else passed++;
    end
    tick;
    checks++;
    if (ifu_rsp_valid !== 1'b1 || rsp_err !== 1'b1 || ifu_rdata !== 32'h0 ||
        lsu_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0)
      $display("[TB] FAIL timeout_abort rsp=%0b err=%0b rdata=%h other=%0b memv=%0b want 1 1 0 0 0",
               ifu_rsp_valid, rsp_err, ifu_rdata, lsu_rsp_valid, mem_req_valid);
    else passed++;
    exp_ifu_rdata = 32'h0;
    ifu_req_valid = 1'b1;
    #1;
    checks++;
    if (ifu_req_ready !== 1'b1) $display("[TB] FAIL timeout_idle ready=%0b want 1", ifu_req_ready);
    else passed++;
    ifu_req_valid = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0 || ifu_rdata !== 32'h0)
        $display("[TB] FAIL stray_response rsp=%0b%0b rdata=%h want 00 0", ifu_rsp_valid, lsu_rsp_valid, ifu_rdata);
      else passed++;
    end
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset_wait;
    lsu_addr = 32'h8000_0010; lsu_wen = 1'b0; lsu_wmask = 4'hF; lsu_req_valid = 1'b1;
    #1;
    tick;
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; rst = 1'b0;
    #1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, rsp_err, mem_req_valid,
         mem_wen, mem_wmask, mem_addr, mem_wdata, ifu_rdata, lsu_rdata} !== '0)
      $display("[TB] FAIL reset_in_wait ready=%0b%0b rsp=%0b%0b memv=%0b addr=%h rdata=%h/%h want all 0",
               ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid,
               mem_addr, ifu_rdata, lsu_rdata);
    else passed++;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    tick; tick;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; rst = 1'b1;
    exp_ifu_rdata = 32'h0; exp_lsu_rdata = 32'h0; last_lsu = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++;
      if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0 || lsu_rdata !== 32'h0)
        $display("[TB] FAIL reset_no_pulse rsp=%0b%0b rdata=%h want 00 0", ifu_rsp_valid, lsu_rsp_valid, lsu_rdata);
      else passed++;
    end
    mem_rsp_valid = 1'b0;
    run_round(1'b0, 1'b1, 32'h0, 32'h8000_0010, 1'b0, 32'h0, 4'hF, 1, 1);
  endtask

  task automatic test_random;
    int pat;
    for (int n = 0; n < 30; n++) begin
      pat = $urandom_range(0, 2);
      run_round(pat != 1, pat != 0,
                32'h8000_0000 | (32'($urandom_range(0, 15)) << 2),
                32'h8000_0000 | (32'($urandom_range(0, 15)) << 2),
                1'($urandom_range(0, 1)), 32'($urandom), 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset;
    test_ifu_read;
    test_collision;
    test_stall;
    test_timeout;
    test_reset_wait;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
